// File: rtl/tlul_sram_responder.sv
// TileLink-UL responder backed by a word-addressed flop memory.
// One registered D slot gives 1-cycle latency and carries backpressure to channel A.
module tlul_sram_responder #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned SRC_W     = 4
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [2:0]       i_a_opcode,
  input  logic [2:0]       i_a_param,
  input  logic [1:0]       i_a_size,
  input  logic [SRC_W-1:0] i_a_source,
  input  logic [31:0]      i_a_address,
  input  logic [3:0]       i_a_mask,
  input  logic [31:0]      i_a_data,
  input  logic             i_a_corrupt,
  output logic             o_d_valid,
  input  logic             i_d_ready,
  output logic [2:0]       o_d_opcode,
  output logic [1:0]       o_d_param,
  output logic [1:0]       o_d_size,
  output logic [SRC_W-1:0] o_d_source,
  output logic             o_d_sink,
  output logic             o_d_denied,
  output logic [31:0]      o_d_data,
  output logic             o_d_corrupt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e r_state, w_state_next;

  logic [31:0]      r_mem [DEPTH];
  logic [2:0]       r_d_opcode;
  logic [1:0]       r_d_size;
  logic [SRC_W-1:0] r_d_source;
  logic             r_d_denied;
  logic [31:0]      r_d_data;
  logic             r_d_corrupt;

  logic             w_a_ready;
  logic             w_accept;
  logic [31:0]      w_offset;
  logic             w_in_range;
  logic [IDX_W-1:0] w_index;
  logic             w_is_put;
  logic             w_is_get;
  logic             w_aligned;
  logic [3:0]       w_lanes;
  logic             w_denied;
  logic             w_write;
  logic             w_unused;

  assign w_a_ready = (r_state == StEmpty) || i_d_ready;
  assign w_accept  = i_a_valid && w_a_ready;

  // BASE_ADDR is span-aligned, so an unsigned offset compare also rejects addresses below base.
  assign w_offset   = i_a_address - BASE_ADDR;
  assign w_in_range = {1'b0, w_offset} < SPAN;
  assign w_index    = w_offset[IDX_W+1:2];

  assign w_is_put = (i_a_opcode == OP_PUT_FULL) || (i_a_opcode == OP_PUT_PARTIAL);
  assign w_is_get = (i_a_opcode == OP_GET);

  always_comb begin
    w_aligned = 1'b0;
    w_lanes   = 4'b1111;
    unique case (i_a_size)
      2'd0: begin
        w_aligned = 1'b1;
        w_lanes   = 4'b0001 << i_a_address[1:0];
      end
      2'd1: begin
        w_aligned = !i_a_address[0];
        w_lanes   = i_a_address[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        w_aligned = (i_a_address[1:0] == 2'b00);
        w_lanes   = 4'b1111;
      end
      default: begin
        w_aligned = 1'b0;
        w_lanes   = 4'b1111;
      end
    endcase
  end

  assign w_denied = !w_in_range
                 || (i_a_size == 2'd3)
                 || !w_aligned
                 || !(w_is_put || w_is_get)
                 || (w_is_put && i_a_corrupt)
                 || ((i_a_opcode == OP_PUT_FULL) && (i_a_mask != w_lanes))
                 || (w_is_put && (i_a_mask == 4'b0000));

  assign w_write = w_accept && w_is_put && !w_denied;

  always_ff @(posedge i_clock) begin
    if (w_write) begin
      for (int b = 0; b < 4; b++) begin
        if (i_a_mask[b]) begin
          r_mem[w_index][8*b +: 8] <= i_a_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StEmpty: if (w_accept) w_state_next = StFull;
      StFull: begin
        if (w_accept)       w_state_next = StFull;
        else if (i_d_ready) w_state_next = StEmpty;
      end
      default: w_state_next = StEmpty;
    endcase
  end

  // Get reads the array before this edge's write; a prior-edge Put is already visible.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_d_opcode  <= 3'd0;
      r_d_size    <= 2'd0;
      r_d_source  <= '0;
      r_d_denied  <= 1'b0;
      r_d_data    <= 32'd0;
      r_d_corrupt <= 1'b0;
    end else if (w_accept) begin
      r_d_opcode  <= w_is_get ? 3'd1 : 3'd0;
      r_d_size    <= i_a_size;
      r_d_source  <= i_a_source;
      r_d_denied  <= w_denied;
      r_d_data    <= (w_is_get && !w_denied) ? r_mem[w_index] : 32'd0;
      r_d_corrupt <= w_is_get && w_denied;
    end
  end

  assign o_a_ready   = w_a_ready;
  assign o_d_valid   = (r_state == StFull);
  assign o_d_opcode  = r_d_opcode;
  assign o_d_param   = 2'd0;
  assign o_d_size    = r_d_size;
  assign o_d_source  = r_d_source;
  assign o_d_sink    = 1'b0;
  assign o_d_denied  = r_d_denied;
  assign o_d_data    = r_d_data;
  assign o_d_corrupt = r_d_corrupt;

  assign w_unused = ^{i_a_param, w_offset[31:IDX_W+2], w_offset[1:0]};

endmodule

// File: tb/tb_tlul_sram_responder.sv
// Bench for tlul_sram_responder: directed scenarios plus random traffic scored
// against a transaction-level model of memory and the single D slot.
module tb_tlul_sram_responder;

  localparam int unsigned DEPTH     = 16;
  localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
  localparam int unsigned SRC_W     = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_valid;
  logic             a_ready;
  logic [2:0]       a_opcode;
  logic [2:0]       a_param;
  logic [1:0]       a_size;
  logic [SRC_W-1:0] a_source;
  logic [31:0]      a_address;
  logic [3:0]       a_mask;
  logic [31:0]      a_data;
  logic             a_corrupt;
  logic             d_valid;
  logic             d_ready;
  logic [2:0]       d_opcode;
  logic [1:0]       d_param;
  logic [1:0]       d_size;
  logic [SRC_W-1:0] d_source;
  logic             d_sink;
  logic             d_denied;
  logic [31:0]      d_data;
  logic             d_corrupt;

  tlul_sram_responder #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR),
    .SRC_W    (SRC_W)
  ) u_dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_a_valid  (a_valid),
    .o_a_ready  (a_ready),
    .i_a_opcode (a_opcode),
    .i_a_param  (a_param),
    .i_a_size   (a_size),
    .i_a_source (a_source),
    .i_a_address(a_address),
    .i_a_mask   (a_mask),
    .i_a_data   (a_data),
    .i_a_corrupt(a_corrupt),
    .o_d_valid  (d_valid),
    .i_d_ready  (d_ready),
    .o_d_opcode (d_opcode),
    .o_d_param  (d_param),
    .o_d_size   (d_size),
    .o_d_source (d_source),
    .o_d_sink   (d_sink),
    .o_d_denied (d_denied),
    .o_d_data   (d_data),
    .o_d_corrupt(d_corrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic             denied;
    logic [31:0]      data;
    logic             corrupt;
    logic [1:0]       size;
    logic [SRC_W-1:0] src;
  } resp_t;

  logic [31:0] m_mem [DEPTH];
  bit          m_full;
  resp_t       m_resp;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte lanes covered by a 2^size access starting at byte offset off.
  function automatic logic [3:0] lanes_of(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if (b >= int'(off) && b < int'(off) + (1 << int'(size))) m[b] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_accept();
    longint      a = longint'(a_address);
    bit          in_range = (a >= longint'(BASE_ADDR)) && (a < longint'(BASE_ADDR) + DEPTH * 4);
    bit          is_put = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    bit          is_get = (a_opcode == 3'd4);
    bit          den;
    int unsigned idx = 0;
    if (in_range) idx = (a_address - BASE_ADDR) / 4;
    den = !in_range || (a_size == 2'd3) || ((a_address % (32'd1 << a_size)) != 0)
       || !(is_put || is_get) || (is_put && a_corrupt)
       || ((a_opcode == 3'd0) && (a_mask != lanes_of(a_size, a_address[1:0])))
       || (is_put && (a_mask == 4'b0000));
    m_resp.op      = is_get ? 3'd1 : 3'd0;
    m_resp.denied  = den;
    m_resp.data    = (is_get && !den) ? m_mem[idx] : 32'd0;
    m_resp.corrupt = is_get && den;
    m_resp.size    = a_size;
    m_resp.src     = a_source;
    if (is_put && !den) begin
      for (int b = 0; b < 4; b++) begin
        if (a_mask[b]) m_mem[idx][8*b +: 8] = a_data[8*b +: 8];
      end
    end
  endtask

  task automatic check_outputs();
    chk("a_ready", {31'd0, a_ready}, {31'd0, !m_full || d_ready});
    chk("d_valid", {31'd0, d_valid}, {31'd0, m_full});
    chk("d_param", {30'd0, d_param}, 32'd0);
    chk("d_sink", {31'd0, d_sink}, 32'd0);
    if (m_full) begin
      chk("d_opcode", {29'd0, d_opcode}, {29'd0, m_resp.op});
      chk("d_denied", {31'd0, d_denied}, {31'd0, m_resp.denied});
      chk("d_data", d_data, m_resp.data);
      chk("d_corrupt", {31'd0, d_corrupt}, {31'd0, m_resp.corrupt});
      chk("d_size", {30'd0, d_size}, {30'd0, m_resp.size});
      chk("d_source", {28'd0, d_source}, {28'd0, m_resp.src});
    end
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge; returns at posedge+1.
  task automatic cycle(input bit v, input logic [2:0] op, input logic [1:0] sz,
                       input logic [31:0] ad, input logic [3:0] mk, input logic [31:0] dt,
                       input bit cr, input logic [SRC_W-1:0] src, input bit rdy);
    bit exp_ready;
    @(negedge clk);
    a_valid = v; a_opcode = op; a_size = sz; a_address = ad; a_mask = mk;
    a_data = dt; a_corrupt = cr; a_source = src; d_ready = rdy;
    a_param = 3'd0;
    #1;
    check_outputs();
    exp_ready = !m_full || rdy;
    @(posedge clk);
    if (v && exp_ready) begin
      model_accept();
      m_full = 1'b1;
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 3'd4, 2'd2, BASE_ADDR, 4'hF, 32'd0, 1'b0, '0, rdy);
  endtask

  logic [31:0] snap_data;
  logic [2:0]  snap_op;
  logic [31:0] r_ad;
  logic [2:0]  r_op;
  logic [1:0]  r_sz;
  logic [3:0]  r_mk;

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 2'd0;
    a_source = '0; a_address = 32'd0; a_mask = 4'd0; a_data = 32'd0; a_corrupt = 1'b0;
    d_ready = 1'b0; m_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_d_opcode", {29'd0, d_opcode}, 32'd0);
    chk("rst_d_data", d_data, 32'd0);
    chk("rst_d_denied", {31'd0, d_denied}, 32'd0);
    chk("rst_d_corrupt", {31'd0, d_corrupt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) begin
      cycle(1'b1, 3'd0, 2'd2, BASE_ADDR + 32'(i * 4), 4'hF, $urandom, 1'b0, 4'(i), 1'b1);
    end

    // Full write then read back
    cycle(1'b1, 3'd0, 2'd2, BASE_ADDR + 8, 4'hF, 32'hDEAD_BEEF, 1'b0, 4'd3, 1'b1);
    chk("t1_put_valid", {31'd0, d_valid}, 32'd1);
    chk("t1_put_op", {29'd0, d_opcode}, 32'd0);
    chk("t1_put_src", {28'd0, d_source}, 32'd3);
    chk("t1_put_denied", {31'd0, d_denied}, 32'd0);
    cycle(1'b1, 3'd4, 2'd2, BASE_ADDR + 8, 4'hF, 32'd0, 1'b0, 4'd5, 1'b1);
    chk("t1_get_op", {29'd0, d_opcode}, 32'd1);
    chk("t1_get_data", d_data, 32'hDEAD_BEEF);

    // Partial write of lane 1
    cycle(1'b1, 3'd1, 2'd2, BASE_ADDR + 8, 4'b0010, 32'h0000_5500, 1'b0, 4'd1, 1'b1);
    cycle(1'b1, 3'd4, 2'd2, BASE_ADDR + 8, 4'hF, 32'd0, 1'b0, 4'd2, 1'b1);
    chk("t2_get_data", d_data, 32'hDEAD_55EF);

    // Out of range Get
    cycle(1'b1, 3'd4, 2'd2, BASE_ADDR + DEPTH * 4, 4'hF, 32'd0, 1'b0, 4'd6, 1'b1);
    chk("t3_op", {29'd0, d_opcode}, 32'd1);
    chk("t3_denied", {31'd0, d_denied}, 32'd1);
    chk("t3_corrupt", {31'd0, d_corrupt}, 32'd1);
    chk("t3_data", d_data, 32'd0);

    // Misaligned Get, bad-mask PutFull, illegal opcode
    cycle(1'b1, 3'd4, 2'd2, BASE_ADDR + 2, 4'hF, 32'd0, 1'b0, 4'd7, 1'b1);
    chk("t4_misalign_denied", {31'd0, d_denied}, 32'd1);
    cycle(1'b1, 3'd0, 2'd1, BASE_ADDR + 8, 4'hF, 32'h1111_1111, 1'b0, 4'd8, 1'b1);
    chk("t4_badmask_denied", {31'd0, d_denied}, 32'd1);
    chk("t4_badmask_op", {29'd0, d_opcode}, 32'd0);
    cycle(1'b1, 3'd5, 2'd2, BASE_ADDR + 8, 4'hF, 32'h2222_2222, 1'b0, 4'd9, 1'b1);
    chk("t4_op5_op", {29'd0, d_opcode}, 32'd0);
    chk("t4_op5_denied", {31'd0, d_denied}, 32'd1);
    cycle(1'b1, 3'd4, 2'd2, BASE_ADDR + 8, 4'hF, 32'd0, 1'b0, 4'd10, 1'b1);
    chk("t4_mem_intact", d_data, 32'hDEAD_55EF);

    // Stall five cycles, then handshake with a new request in the same cycle
    cycle(1'b1, 3'd4, 2'd2, BASE_ADDR + 8, 4'hF, 32'd0, 1'b0, 4'd11, 1'b1);
    snap_data = d_data;
    snap_op   = d_opcode;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 3'd0, 2'd2, BASE_ADDR + 12, 4'hF, 32'h3333_3333, 1'b0, 4'd12, 1'b0);
      chk("t5_stall_ready", {31'd0, a_ready}, 32'd0);
      chk("t5_stall_data", d_data, snap_data);
      chk("t5_stall_op", {29'd0, d_opcode}, {29'd0, snap_op});
      chk("t5_stall_src", {28'd0, d_source}, 32'd11);
    end
    cycle(1'b1, 3'd4, 2'd2, BASE_ADDR + 4, 4'hF, 32'd0, 1'b0, 4'd13, 1'b1);
    chk("t5_nobubble_valid", {31'd0, d_valid}, 32'd1);
    chk("t5_nobubble_src", {28'd0, d_source}, 32'd13);

    // Reset mid-stall
    cycle(1'b1, 3'd0, 2'd2, BASE_ADDR + 16, 4'hF, 32'hCAFE_F00D, 1'b0, 4'd14, 1'b1);
    idle(1'b0);
    @(negedge clk);
    a_valid = 1'b0;
    d_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, d_valid}, 32'd0);
    chk("t6_async_data", d_data, 32'd0);
    chk("t6_async_src", {28'd0, d_source}, 32'd0);
    m_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 3'd4, 2'd2, BASE_ADDR + 16, 4'hF, 32'd0, 1'b0, 4'd15, 1'b1);
    chk("t6_readback", d_data, 32'hCAFE_F00D);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      int unsigned pick = $urandom_range(0, 9);
      if (pick < 8)       r_ad = BASE_ADDR + 32'($urandom_range(0, DEPTH * 4 - 1));
      else if (pick == 8) r_ad = BASE_ADDR + DEPTH * 4 + 32'($urandom_range(0, 15));
      else                r_ad = $urandom;
      pick = $urandom_range(0, 7);
      r_sz = (pick == 7) ? 2'd3 : 2'(pick % 3);
      if (r_sz != 2'd3 && $urandom_range(0, 3) != 0) r_ad = r_ad & ~((32'd1 << r_sz) - 32'd1);
      pick = $urandom_range(0, 9);
      r_op = (pick < 3) ? 3'd0 : (pick < 6) ? 3'd1 : (pick < 9) ? 3'd4 : 3'($urandom_range(0, 7));
      r_mk = ($urandom_range(0, 4) != 0) ? lanes_of(r_sz, r_ad[1:0]) : 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 4) != 0, r_op, r_sz, r_ad, r_mk, $urandom,
            $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    repeat (3) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
